// File: rtl/bp_sc_arbiter.sv
// Two-requester round-robin front end for the backplane slow-control SPI engine.
// Optional ISSUE watchdog enabled by defining BP_SC_TIMEOUT_EN.
module bp_sc_arbiter #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk_66m,
  input  logic             rst_n,
  input  logic             sc_req0,
  input  logic [31:0]      sc_wdata0,
  output logic             sc_ack0,
  input  logic             sc_req1,
  input  logic [31:0]      sc_wdata1,
  output logic             sc_ack1,
  output logic [31:0]      sc_rdata,
  output logic             sc_err,
  output logic             sc_busy,
  output logic             sc_grant,
  output logic [CNT_W-1:0] txn_count,
  output logic             command_bp_sc_write,
  output logic [31:0]      BP_SC_SENDDATA,
  input  logic             bp_sc_write_done,
  input  logic [31:0]      BP_SC_READ
);

  // state   | meaning
  // IDLE    | no transaction, arbitrate pending requests
  // ISSUE   | command high, waiting for engine done
  // RELEASE | command low, waiting for engine done to clear
  // RESP    | one-cycle ack to the granted requester
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

  state_t state;
  logic   winner;

  // On contention the requester opposite the last grant wins.
  assign winner = (sc_req0 & sc_req1) ? ~sc_grant : sc_req1;

`ifdef BP_SC_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign sc_err = 1'b0;
`endif

  always_ff @(posedge clk_66m or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      sc_ack0             <= 1'b0;
      sc_ack1             <= 1'b0;
      sc_rdata            <= '0;
      sc_busy             <= 1'b0;
      sc_grant            <= 1'b1;
      txn_count           <= '0;
      command_bp_sc_write <= 1'b0;
      BP_SC_SENDDATA      <= '0;
`ifdef BP_SC_TIMEOUT_EN
      sc_err              <= 1'b0;
      tmo_cnt             <= '0;
`endif
    end else begin
      sc_ack0 <= 1'b0;
      sc_ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (sc_req0 | sc_req1) begin
            sc_grant            <= winner;
            BP_SC_SENDDATA      <= winner ? sc_wdata1 : sc_wdata0;
            command_bp_sc_write <= 1'b1;
            sc_busy             <= 1'b1;
            state               <= ISSUE;
`ifdef BP_SC_TIMEOUT_EN
            tmo_cnt             <= TMO_W'(TIMEOUT_CYC - 1);
`endif
          end
        end
        ISSUE: begin
          if (bp_sc_write_done) begin
            sc_rdata            <= BP_SC_READ;
            command_bp_sc_write <= 1'b0;
            state               <= RELEASE;
`ifdef BP_SC_TIMEOUT_EN
            sc_err              <= 1'b0;
          end else if (tmo_cnt == '0) begin
            sc_rdata            <= 32'hFFFF_FFFF;
            sc_err              <= 1'b1;
            command_bp_sc_write <= 1'b0;
            state               <= RELEASE;
          end else begin
            tmo_cnt             <= tmo_cnt - 1'b1;
`endif
          end
        end
        RELEASE: begin
          if (!bp_sc_write_done) begin
            sc_ack0 <= ~sc_grant;
            sc_ack1 <= sc_grant;
            state   <= RESP;
          end
        end
        RESP: begin
          txn_count <= txn_count + CNT_W'(1);
          sc_busy   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sc_arbiter.sv
// Randomised bench for bp_sc_arbiter with a transaction-level arbitration model
// and a cycle-counting SPI engine model.
module tb_bp_sc_arbiter;

`ifdef BP_SC_TIMEOUT_EN
  localparam int TMO = 64;
  localparam int T1_DELAY = 40;
`else
  localparam int TMO = 4096;
  localparam int T1_DELAY = 1071;
`endif

  logic        clk_66m = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        ack0, ack1, err, busy, grant, cmd;
  logic [31:0] rdata, senddata;
  logic [15:0] txn_count;
  logic        done = 1'b0;
  logic [31:0] read = '0;

  always #5 clk_66m = ~clk_66m;

  bp_sc_arbiter #(.TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .clk_66m(clk_66m), .rst_n(rst_n),
    .sc_req0(req0), .sc_wdata0(wd0), .sc_ack0(ack0),
    .sc_req1(req1), .sc_wdata1(wd1), .sc_ack1(ack1),
    .sc_rdata(rdata), .sc_err(err), .sc_busy(busy), .sc_grant(grant),
    .txn_count(txn_count), .command_bp_sc_write(cmd), .BP_SC_SENDDATA(senddata),
    .bp_sc_write_done(done), .BP_SC_READ(read)
  );

  int n_vec = 0, n_err = 0, cyc = 0, n_txn = 0;
  int last_grant, idle_wait, exp_ack_cyc, exp_cnt, g_cyc;
  bit m_idle, exp_err;
  logic [31:0] exp_data, exp_rdata;
  int eng_st, eng_cnt, eng_hold, dmin = 0, dmax = 0, eng_extra = 0, p0 = 0, p1 = 0;
  bit eng_never = 0, fix_rd = 0;
  logic [31:0] rd_val = '0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    last_grant = 1; m_idle = 1; idle_wait = 0; exp_ack_cyc = -1; exp_cnt = 0;
    exp_err = 0; eng_st = 0; done = 1'b0; read = '0; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic eval_cycle();
    int w;
    logic r0, r1;
    bit a_exp;
    r0 = req0; r1 = req1;
    if (m_idle) begin
      if (r0 || r1) begin
        w = (r0 && r1) ? 1 - last_grant : (r1 ? 1 : 0);
        exp_data = (w == 1) ? wd1 : wd0;
        chk_val("grant_cmd", 32'(cmd), 32'd1);
        chk_val("grant_idx", 32'(grant), 32'(w));
        chk_val("grant_data", senddata, exp_data);
        chk_val("busy_set", 32'(busy), 32'd1);
        last_grant = w; m_idle = 0; g_cyc = cyc; exp_err = 0;
        if (eng_never) begin
          exp_ack_cyc = cyc + TMO + 1; exp_rdata = 32'hFFFF_FFFF; exp_err = 1;
        end
      end else chk_val("idle_cmd", 32'(cmd), 32'd0);
    end else if (idle_wait > 0) begin
      idle_wait = 0; m_idle = 1;
      chk_val("busy_clr", 32'(busy), 32'd0);
      chk_val("txn_count", 32'(txn_count), 32'(exp_cnt));
    end

    a_exp = (cyc == exp_ack_cyc);
    if (ack0 || ack1 || a_exp) begin
      chk_val("ack0", 32'(ack0), 32'(a_exp && last_grant == 0));
      chk_val("ack1", 32'(ack1), 32'(a_exp && last_grant == 1));
      if (a_exp) begin
        chk_val("ack_rdata", rdata, exp_rdata);
        chk_val("ack_err", 32'(err), 32'(exp_err));
        idle_wait = 1; exp_cnt = (exp_cnt + 1) % 65536; n_txn++; exp_ack_cyc = -1;
      end
    end

    case (eng_st)
      0: if (cmd) begin
           if (eng_never) eng_st = 4;
           else begin eng_cnt = int'($urandom_range(dmax, dmin)); eng_st = 1; end
         end
      1: if (eng_cnt == 0) begin
           chk_val("cmd_hold", 32'(cmd), 32'd1);
           chk_val("data_hold", senddata, exp_data);
           done = 1'b1; read = fix_rd ? rd_val : $urandom; exp_rdata = read; eng_st = 2;
         end else eng_cnt--;
      2: begin
           chk_val("cmd_fall", 32'(cmd), 32'd0);
           chk_val("rdata_cap", rdata, exp_rdata);
           eng_hold = eng_extra; eng_st = 3;
         end
      3: begin
           chk_val("no_recmd", 32'(cmd), 32'd0);
           if (eng_hold == 0) begin
             done = 1'b0; read = $urandom; exp_ack_cyc = cyc + 1; eng_st = 0;
           end else eng_hold--;
         end
      4: if (!cmd) begin chk_val("tmo_len", 32'(cyc - g_cyc), 32'(TMO)); eng_st = 0; end
      default: eng_st = 0;
    endcase

    if (req0 && ack0) req0 = 1'b0;
    else if (!req0 && int'($urandom_range(99)) < p0) begin req0 = 1'b1; wd0 = $urandom; end
    if (req1 && ack1) req1 = 1'b0;
    else if (!req1 && int'($urandom_range(99)) < p1) begin req1 = 1'b1; wd1 = $urandom; end
  endtask

  task automatic tick();
    @(posedge clk_66m);
    #1;
    cyc++;
    if (rst_n) eval_cycle();
  endtask

  task automatic run_txns(input int n, input int budget);
    int start, k;
    start = n_txn; k = 0;
    while (n_txn - start < n && k < budget) begin tick(); k++; end
    chk_val("txn_done", 32'(n_txn - start), 32'(n));
  endtask

  task automatic drain(input int budget);
    int k;
    p0 = 0; p1 = 0; k = 0;
    while (!(m_idle && !req0 && !req1) && k < budget) begin tick(); k++; end
    chk_val("drain", {29'd0, req0, req1, ~m_idle}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    @(negedge clk_66m);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    model_reset();
    #12;
    chk_val("rst_cmd", 32'(cmd), 32'd0);
    chk_val("rst_grant", 32'(grant), 32'd1);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_count", 32'(txn_count), 32'd0);
    chk_val("rst_rdata", rdata, 32'd0);
    chk_val("rst_send", senddata, 32'd0);
    chk_val("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    chk_val("rst_err", 32'(err), 32'd0);
    @(negedge clk_66m);
    rst_n = 1'b1;

    // single long transaction from requester 0
    req0 = 1'b1; wd0 = 32'hA5A5_0F0F;
    dmin = T1_DELAY; dmax = T1_DELAY; fix_rd = 1; rd_val = 32'h1234_5678;
    run_txns(1, 1300);
    drain(20);
    chk_val("t1_count", 32'(txn_count), 32'd1);
    fix_rd = 0;

    // both requesting from reset: alternating grants
    do_reset();
    req0 = 1'b1; wd0 = $urandom; req1 = 1'b1; wd1 = $urandom;
    p0 = 100; p1 = 100; dmin = 0; dmax = 8;
    run_txns(6, 400);
    drain(100);

    // requester 1 arrives while requester 0 is in ISSUE
    req0 = 1'b1; wd0 = $urandom; dmin = 10; dmax = 10;
    k = 0;
    while (eng_st != 1 && k < 20) begin tick(); k++; end
    chk_val("t3_issue", 32'(eng_st), 32'd1);
    tick();
    req1 = 1'b1; wd1 = $urandom;
    run_txns(2, 100);
    drain(20);

    // engine holds done after command falls
    eng_extra = 5; dmin = 3; dmax = 3;
    req0 = 1'b1; wd0 = $urandom;
    run_txns(1, 60);
    drain(20);
    eng_extra = 0;

    // reset in the middle of ISSUE
    req1 = 1'b1; wd1 = $urandom; dmin = 200; dmax = 200;
    k = 0;
    while (eng_st != 1 && k < 20) begin tick(); k++; end
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_val("arst_cmd", 32'(cmd), 32'd0);
    chk_val("arst_grant", 32'(grant), 32'd1);
    chk_val("arst_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) tick();
    @(negedge clk_66m);
    rst_n = 1'b1;
    req0 = 1'b1; wd0 = $urandom; req1 = 1'b1; wd1 = $urandom; dmin = 0; dmax = 5;
    run_txns(2, 100);
    drain(20);

`ifdef BP_SC_TIMEOUT_EN
    eng_never = 1;
    req0 = 1'b1; wd0 = $urandom;
    run_txns(1, TMO + 20);
    drain(20);
    eng_never = 0;
`endif

    // random traffic
    p0 = 30; p1 = 30; dmin = 0; dmax = 30; eng_extra = 2;
    run_txns(40, 4000);
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
